// File: rtl/latch_write_arbiter_pkg.sv
// Shared types and constants for the latch write arbiter.
package latch_write_arbiter_pkg;

    // Write sequence: data is set up, the latch enable pulses, then data is held.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StEnable = 2'd2,
        StHold   = 2'd3
    } state_e;

    // Pointer starts at requester 1, so requester 0 wins the first tie.
    localparam logic RR_RESET_PTR = 1'b1;

endpackage

// File: rtl/latch_write_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic winner,
    output logic any
);

    // A lone request wins; on a tie, the requester not named by the pointer wins.
    always_comb begin
        any    = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~ptr;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/latch_write_arbiter.sv
// Arbitrates two requesters onto one latch bank with a setup/enable/hold write.
module latch_write_arbiter
    import latch_write_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             c,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic             le,
    output logic [WIDTH-1:0] ld,
    output logic             busy,
    output logic             owner,
    output logic             valid
);

    state_e           state_q, state_d;
    logic             ptr_q;
    logic             gidx_q;
    logic [WIDTH-1:0] ld_q;
    logic             owner_q;
    logic             valid_q;
    logic             win;
    logic             any_req;
    logic             grant;

    rr_arb2 u_arb (
        .req0   (req0),
        .req1   (req1),
        .ptr    (ptr_q),
        .winner (win),
        .any    (any_req)
    );

    // Grant edge: leaving IDLE with at least one request pending.
    assign grant = (state_q == StIdle) && any_req;

    // Next-state logic; the write sequence never stalls or aborts once started.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = StSetup;
            StSetup:  state_d = StEnable;
            StEnable: state_d = StHold;
            StHold:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State, round-robin pointer, captured data and ownership registers.
    always_ff @(posedge c) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= RR_RESET_PTR;
            gidx_q  <= 1'b0;
            ld_q    <= '0;
            owner_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                ptr_q  <= win;
                gidx_q <= win;
                ld_q   <= win ? d1 : d0;
            end
            if (state_q == StHold) begin
                owner_q <= gidx_q;
                valid_q <= 1'b1;
            end
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        busy  = (state_q != StIdle);
        gnt0  = busy & ~gidx_q;
        gnt1  = busy & gidx_q;
        le    = (state_q == StEnable);
        ack0  = (state_q == StHold) & ~gidx_q;
        ack1  = (state_q == StHold) & gidx_q;
        ld    = ld_q;
        owner = owner_q;
        valid = valid_q;
    end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Scoreboard bench for latch_write_arbiter: stimulus pushes expected writes,
// a monitor pops and checks them on every le pulse and ack.
module tb_latch_write_arbiter;

    logic       c = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] d0 = '0, d1 = '0;
    logic       gnt0, gnt1, ack0, ack1, le, busy, owner, valid;
    logic [3:0] ld;

    typedef struct {
        logic       idx;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    latch_write_arbiter #(.WIDTH(4)) dut (
        .c     (c),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .d0    (d0),
        .d1    (d1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .ack0  (ack0),
        .ack1  (ack1),
        .le    (le),
        .ld    (ld),
        .busy  (busy),
        .owner (owner),
        .valid (valid)
    );

    always #5 c = ~c;
    always @(posedge c) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every le pulse and ack against the front of the scoreboard.
    logic le_prev = 1'b0;
    logic owner_chk = 1'b0;
    logic exp_owner = 1'b0;
    always @(negedge c) begin
        if (rst) begin
            le_prev   = 1'b0;
            owner_chk = 1'b0;
        end else begin
            if (owner_chk) begin
                check("mon_owner", 32'(owner), 32'(exp_owner));
                check("mon_valid", 32'(valid), 32'd1);
                owner_chk = 1'b0;
            end
            if (le) begin
                if (sb.size() == 0) fail("mon_le_without_request");
                else begin
                    check("mon_le_ld", 32'(ld), 32'(sb[0].data));
                    check("mon_le_gnt", 32'({gnt1, gnt0}), sb[0].idx ? 32'd2 : 32'd1);
                end
            end
            if (ack0 || ack1) begin
                if (sb.size() == 0) fail("mon_ack_without_request");
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("mon_ack_idx", 32'({ack1, ack0}), e.idx ? 32'd2 : 32'd1);
                    check("mon_ack_ld", 32'(ld), 32'(e.data));
                    check("mon_le_before_ack", 32'({le_prev, le}), 32'b10);
                    owner_chk = 1'b1;
                    exp_owner = e.idx;
                end
            end
            le_prev = le;
        end
    end

    task automatic do_reset();
        @(negedge c);
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge c);
        @(negedge c);
        sb.delete();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int le_rise[$];
        int n_ack;
        bit done;
        logic le_l;

        // Reset then idle: every output stays low.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge c);
            check("idle_outputs", 32'({gnt0, gnt1, ack0, ack1, le, ld, busy, owner, valid}), 32'd0);
        end

        // Single write from requester 0, checked cycle by cycle.
        @(negedge c);
        req0 = 1'b1;
        d0 = 4'hA;
        sb.push_back('{idx: 1'b0, data: 4'hA});
        @(negedge c);
        check("w0_setup", 32'({gnt0, gnt1, busy, le, ack0, ld}), {27'd0, 5'b10100} << 4 | 32'hA);
        @(negedge c);
        check("w0_enable", 32'({gnt0, le, ack0, ld}), 32'b1_1_0_1010);
        @(negedge c);
        check("w0_hold", 32'({gnt0, le, ack0, ld}), 32'b1_0_1_1010);
        req0 = 1'b0;
        @(negedge c);
        check("w0_idle", 32'({gnt0, busy, owner, valid, ld}), 32'b0_0_0_1_1010);

        // Simultaneous requests after reset: req0 first, then req1 four cycles later.
        do_reset();
        @(negedge c);
        req0 = 1'b1;
        req1 = 1'b1;
        d0 = 4'h3;
        d1 = 4'hC;
        sb.push_back('{idx: 1'b0, data: 4'h3});
        sb.push_back('{idx: 1'b1, data: 4'hC});
        le_l = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge c);
            if (le && !le_l) le_rise.push_back(cyc);
            le_l = le;
            if (ack0) req0 = 1'b0;
            if (ack1) begin
                req1 = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) fail("tie_ack1_timeout");
        check("tie_le_pulses", 32'(le_rise.size()), 32'd2);
        if (le_rise.size() == 2) check("tie_le_gap", 32'(le_rise[1] - le_rise[0]), 32'd4);
        @(negedge c);
        check("tie_final_owner", 32'({owner, valid}), 32'b11);

        // Data changed during SETUP is ignored.
        @(negedge c);
        req0 = 1'b1;
        d0 = 4'h5;
        sb.push_back('{idx: 1'b0, data: 4'h5});
        @(negedge c);
        d0 = 4'hF;
        check("hold_setup_ld", 32'(ld), 32'h5);
        @(negedge c);
        check("hold_enable_ld", 32'(ld), 32'h5);
        @(negedge c);
        check("hold_hold_ld", 32'({ack0, ld}), 32'h15);
        req0 = 1'b0;

        // One-cycle pulse on req1 still completes exactly one write.
        @(negedge c);
        @(negedge c);
        req1 = 1'b1;
        d1 = 4'h6;
        sb.push_back('{idx: 1'b1, data: 4'h6});
        @(negedge c);
        req1 = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge c);
            if (ack1) n_ack++;
            if (ack0) fail("pulse_unexpected_ack0");
        end
        check("pulse_ack1_count", 32'(n_ack), 32'd1);
        check("pulse_owner", 32'({owner, valid, ld}), 32'b1_1_0110);

        // Reset during ENABLE aborts the sequence.
        do_reset();
        @(negedge c);
        req0 = 1'b1;
        d0 = 4'h7;
        sb.push_back('{idx: 1'b0, data: 4'h7});
        @(negedge c);
        @(negedge c);
        check("rst_pre_enable", 32'(le), 32'd1);
        rst = 1'b1;
        req0 = 1'b0;
        @(negedge c);
        check("rst_mid_write", 32'({le, gnt0, gnt1, busy, ack0, ack1, valid}), 32'd0);
        sb.delete();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge c);
            check("rst_after_idle", 32'({le, busy, ack0, ack1, valid}), 32'd0);
        end

        if (sb.size() != 0) fail("scoreboard_not_drained");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
